// File: rtl/aes_byte_if.sv
// rtl/aes_byte_if.sv - byte-wide host front end for AES (CBC chaining built only when AES_CBC_EN is defined)

// Iterative AES-128/256 engine: one round key per cycle during expansion, one round per cycle while processing.
module aes_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
  input  logic         next,
  input  logic         encdec,
  input  logic         keylen,
  input  logic [255:0] key,
  input  logic [127:0] block,
  output logic         key_ready,
  output logic         busy,
  output logic         key_done,
  output logic         done,
  output logic [127:0] result
);
  typedef enum logic [1:0] {C_IDLE, C_KEXP, C_ROUND} core_state_t;
  core_state_t state_q, state_d;

  logic [127:0] rk [0:15];
  logic [127:0] kp_q, kpp_q, st_q, kx_base, rnd_key, round_out;
  logic [31:0]  kx_temp, n0, n1, n2, n3, kw;
  logic [3:0]   grp_q, rnd_q, nr_q;
  logic [7:0]   rcon_q;
  logic         enc_q, rot_step, last_rnd;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8); 0 maps to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), x);
    return gf_mul(r, r);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  // byte 4c+r of the state (row r, column c) sits at bits [8*(15-(4c+r)) +: 8]
  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [127:0] t;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[8*(15-(4*c+r)) +: 8] = sbox(s[8*(15-(4*((c+r)%4)+r)) +: 8]);
    if (!last)
      for (int c = 0; c < 4; c++) t[32*(3-c) +: 32] = mix_col(t[32*(3-c) +: 32]);
    return t ^ k;
  endfunction

  function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [127:0] t;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[8*(15-(4*c+r)) +: 8] = inv_sbox(s[8*(15-(4*((c-r+4)%4)+r)) +: 8]);
    t = t ^ k;
    if (!last)
      for (int c = 0; c < 4; c++) t[32*(3-c) +: 32] = inv_mix_col(t[32*(3-c) +: 32]);
    return t;
  endfunction

  // AES-256 odd groups use SubWord only; every other group rotates and adds rcon
  assign rot_step  = (nr_q != 4'd14) || !grp_q[0];
  assign kw        = kp_q[31:0];
  assign kx_temp   = rot_step ? (sub_word({kw[23:0], kw[31:24]}) ^ {rcon_q, 24'h0}) : sub_word(kw);
  assign kx_base   = (nr_q == 4'd14) ? kpp_q : kp_q;
  assign n0        = kx_base[127:96] ^ kx_temp;
  assign n1        = kx_base[95:64] ^ n0;
  assign n2        = kx_base[63:32] ^ n1;
  assign n3        = kx_base[31:0] ^ n2;

  assign last_rnd  = (rnd_q == nr_q);
  assign rnd_key   = enc_q ? rk[rnd_q] : rk[nr_q - rnd_q];
  assign round_out = enc_q ? enc_round(st_q, rnd_key, last_rnd) : dec_round(st_q, rnd_key, last_rnd);

  assign busy      = (state_q != C_IDLE);
  assign key_done  = (state_q == C_KEXP) && (grp_q == nr_q);
  assign done      = (state_q == C_ROUND) && last_rnd;
  assign result    = round_out;

  // engine state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= C_IDLE;
    else     state_q <= state_d;
  end

  // engine sequencing: expand keys on init, run rounds on next once keys exist
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:  if (init) state_d = C_KEXP;
               else if (next && key_ready) state_d = C_ROUND;
      C_KEXP:  if (grp_q == nr_q) state_d = C_IDLE;
      C_ROUND: if (last_rnd) state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  // key schedule storage and round state
  always_ff @(posedge clk) begin
    if (rst) begin
      key_ready <= 1'b0;
      nr_q      <= 4'd10;
      grp_q     <= 4'd0;
      rnd_q     <= 4'd0;
      rcon_q    <= 8'h00;
      enc_q     <= 1'b0;
      kp_q      <= '0;
      kpp_q     <= '0;
      st_q      <= '0;
    end else begin
      case (state_q)
        C_IDLE: begin
          if (init) begin
            key_ready <= 1'b0;
            nr_q      <= keylen ? 4'd14 : 4'd10;
            rcon_q    <= 8'h01;
            rk[0]     <= key[255:128];
            kpp_q     <= key[255:128];
            if (keylen) begin
              rk[1] <= key[127:0];
              kp_q  <= key[127:0];
              grp_q <= 4'd2;
            end else begin
              kp_q  <= key[255:128];
              grp_q <= 4'd1;
            end
          end else if (next && key_ready) begin
            enc_q <= encdec;
            st_q  <= block ^ (encdec ? rk[0] : rk[nr_q]);
            rnd_q <= 4'd1;
          end
        end
        C_KEXP: begin
          rk[grp_q] <= {n0, n1, n2, n3};
          kpp_q     <= kp_q;
          kp_q      <= {n0, n1, n2, n3};
          grp_q     <= grp_q + 4'd1;
          if (rot_step) rcon_q <= xtime(rcon_q);
          if (grp_q == nr_q) key_ready <= 1'b1;
        end
        C_ROUND: begin
          st_q  <= round_out;
          rnd_q <= rnd_q + 4'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

module aes_byte_if (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  address,
  input  logic [15:0] data_in,
  output logic [7:0]  data_out
);
  localparam logic [3:0] A_IDLE = 4'd0, A_CONFIG = 4'd1, A_KEY = 4'd2, A_BLOCK = 4'd3;
  localparam logic [3:0] A_STATUS = 4'd5, A_START = 4'd6, A_RESULT = 4'd7;

  typedef enum logic [2:0] {S_NONE, S_KEY, S_BLOCK, S_IV, S_RESULT} stream_t;
  stream_t stream_q, stream_d;

  logic [3:0]   cnt_q, cnt_d, last_idx;
  logic         encdec_q, keylen_q, mode, ready_q, valid_q;
  logic [255:0] key_q;
  logic [127:0] block_q, result_q, core_in, core_out;
  logic         init_go, next_go, core_key_ready, core_busy, core_key_done, core_done, word_slot;

  assign word_slot = (address == A_IDLE);
  assign init_go   = (address == A_START) && data_in[0] && !core_busy;
  assign next_go   = (address == A_START) && data_in[1] && !init_go && core_key_ready && !core_busy;

  aes_core u_core (
    .clk       (clk),
    .rst       (rst),
    .init      (init_go),
    .next      (next_go),
    .encdec    (encdec_q),
    .keylen    (keylen_q),
    .key       (key_q),
    .block     (core_in),
    .key_ready (core_key_ready),
    .busy      (core_busy),
    .key_done  (core_key_done),
    .done      (core_done),
    .result    (core_out)
  );

  // index of the final word/byte for the active stream
  always_comb begin
    last_idx = 4'd7;
    if (stream_q == S_KEY)    last_idx = keylen_q ? 4'd15 : 4'd7;
    if (stream_q == S_RESULT) last_idx = 4'd15;
  end

  // stream state register
  always_ff @(posedge clk) begin
    if (rst) begin
      stream_q <= S_NONE;
      cnt_q    <= 4'd0;
    end else begin
      stream_q <= stream_d;
      cnt_q    <= cnt_d;
    end
  end

  // any non-IDLE address replaces the current stream; IDLE cycles advance it
  always_comb begin
    stream_d = stream_q;
    cnt_d    = cnt_q;
    if (address != A_IDLE) begin
      cnt_d = 4'd0;
      case (address)
        A_KEY:    stream_d = S_KEY;
        A_BLOCK:  stream_d = S_BLOCK;
`ifdef AES_CBC_EN
        4'd8:     stream_d = S_IV;
`endif
        A_RESULT: begin
          stream_d = S_RESULT;
          cnt_d    = 4'd1;
        end
        default:  stream_d = S_NONE;
      endcase
    end else if (stream_q != S_NONE) begin
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == last_idx) stream_d = S_NONE;
    end
  end

  // configuration, key and block capture
  always_ff @(posedge clk) begin
    if (rst) begin
      encdec_q <= 1'b0;
      keylen_q <= 1'b0;
      key_q    <= '0;
      block_q  <= '0;
    end else begin
      if (address == A_CONFIG) begin
        encdec_q <= data_in[0];
        keylen_q <= data_in[1];
      end
      if (word_slot && stream_q == S_KEY)   key_q[{~cnt_q, 4'b0} +: 16] <= data_in;
      if (word_slot && stream_q == S_BLOCK) block_q[{~cnt_q[2:0], 4'b0} +: 16] <= data_in;
    end
  end

`ifdef AES_CBC_EN
  logic [127:0] chain_q;
  logic         op_enc_q, op_dec_q;

  assign core_in = (mode && encdec_q) ? (block_q ^ chain_q) : block_q;

  // chaining: mode is sampled when a block is launched, chain follows ciphertext
  always_ff @(posedge clk) begin
    if (rst) begin
      mode     <= 1'b0;
      chain_q  <= '0;
      op_enc_q <= 1'b0;
      op_dec_q <= 1'b0;
      result_q <= '0;
    end else begin
      if (address == A_CONFIG) mode <= data_in[2];
      if (next_go) begin
        op_enc_q <= mode && encdec_q;
        op_dec_q <= mode && !encdec_q;
      end
      if (word_slot && stream_q == S_IV) chain_q[{~cnt_q[2:0], 4'b0} +: 16] <= data_in;
      if (core_done) begin
        result_q <= op_dec_q ? (core_out ^ chain_q) : core_out;
        if (op_enc_q)      chain_q <= core_out;
        else if (op_dec_q) chain_q <= block_q;
      end
    end
  end
`else
  assign mode    = 1'b0;
  assign core_in = block_q;

  // result capture when the engine finishes a block
  always_ff @(posedge clk) begin
    if (rst)            result_q <= '0;
    else if (core_done) result_q <= core_out;
  end
`endif

  // status flags: ready tracks a finished key schedule, valid a stored result
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (core_key_done)      ready_q <= 1'b1;
      if (next_go)            ready_q <= 1'b0;
      if (init_go || next_go) valid_q <= 1'b0;
      if (core_done)          valid_q <= 1'b1;
    end
  end

  // registered read port
  always_ff @(posedge clk) begin
    if (rst) data_out <= 8'h00;
    else begin
      case (address)
        A_STATUS: data_out <= {6'b0, valid_q, ready_q};
        A_START:  data_out <= {3'b0, mode, keylen_q, encdec_q, data_in[1:0]};
        A_RESULT: data_out <= result_q[127:120];
        A_IDLE:   data_out <= (stream_q == S_RESULT) ? result_q[{~cnt_q, 3'b0} +: 8] : 8'h00;
        default:  data_out <= 8'h00;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_byte_if.sv
// tb/tb_aes_byte_if.sv - scoreboard bench for aes_byte_if
module tb_aes_byte_if;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  address = 4'd0;
  logic [15:0] data_in = 16'h0;
  logic [7:0]  data_out;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];

  localparam logic [255:0] KEY256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEYCBC  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] IV      = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT0     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT256   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CBC_P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CBC_C1  = 128'hf58c4c04d6e5f1ba779eabfb5f7bfbd6;
  localparam logic [127:0] CBC_P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CBC_C2  = 128'h9cfc4e967edb808d679f777bc6702c7d;

  aes_byte_if dut (
    .clk      (clk),
    .rst      (rst),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h", tag, got, want);
    end
  endtask

  task automatic step(input logic [3:0] a, input logic [15:0] d);
    address = a;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic score();
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard: got %02h expected queued value", data_out);
    end else begin
      check_eq(tag_q.pop_front(), data_out, exp_q.pop_front());
    end
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [15:0] d, input logic [7:0] v);
    expect_out(tag, v);
    step(a, d);
    score();
  endtask

  task automatic load(input logic [3:0] a, input logic [255:0] w, input int n);
    step(a, 16'h0);
    for (int i = 0; i < n; i++) step(4'd0, w[255-16*i -: 16]);
  endtask

  task automatic poll(input string tag, input logic [7:0] v);
    int n;
    n = 0;
    expect_out(tag, v);
    do begin
      step(4'd5, 16'h0);
      n++;
    end while (data_out !== v && n < 21);
    score();
  endtask

  task automatic read_result(input string tag, input logic [127:0] r);
    for (int i = 0; i < 16; i++) expect_out(tag, r[127-8*i -: 8]);
    step(4'd7, 16'h0);
    score();
    for (int i = 1; i < 16; i++) begin
      step(4'd0, 16'h0);
      score();
    end
    rd({tag, "_end"}, 4'd0, 16'h0, 8'h00);
  endtask

  task automatic run_block(input string tag, input logic [127:0] blk, input logic [127:0] res);
    load(4'd3, {blk, 128'h0}, 8);
    step(4'd6, 16'h0002);
    poll({tag, "_valid"}, 8'h02);
    read_result(tag, res);
  endtask

  initial begin
    expect_out("reset_out", 8'h00);
    step(4'd0, 16'h0);
    score();
    step(4'd0, 16'h0);
    rst = 1'b0;

    rd("idle", 4'd0, 16'habcd, 8'h00);
    rd("start0", 4'd6, 16'h0000, 8'h00);
    rd("status0", 4'd5, 16'h0000, 8'h00);
    rd("result0", 4'd7, 16'h0000, 8'h00);

    rd("cfg_wr7", 4'd1, 16'h0007, 8'h00);
`ifdef AES_CBC_EN
    rd("cfg7", 4'd6, 16'h0000, 8'b00011100);
    rd("cfg_wr6", 4'd1, 16'h0006, 8'h00);
    rd("cfg6", 4'd6, 16'h0000, 8'b00011000);
`else
    rd("cfg7", 4'd6, 16'h0000, 8'b00001100);
    rd("cfg_wr6", 4'd1, 16'h0006, 8'h00);
    rd("cfg6", 4'd6, 16'h0000, 8'b00001000);
`endif

    step(4'd1, 16'h0003);
    load(4'd2, KEY256, 16);
    rd("init_echo", 4'd6, 16'h0001, 8'b00001101);
    poll("kexp256", 8'h01);
    run_block("ecb256e", PT0, CT256);

    step(4'd1, 16'h0000);
    load(4'd2, KEY128, 8);
    step(4'd6, 16'h0001);
    poll("kexp128", 8'h01);
    run_block("ecb128d", CT128, PT0);

`ifdef AES_CBC_EN
    step(4'd1, 16'h0007);
    load(4'd2, KEYCBC, 16);
    load(4'd8, {IV, 128'h0}, 8);
    step(4'd6, 16'h0001);
    poll("kexpcbc", 8'h01);
    run_block("cbc_e1", CBC_P1, CBC_C1);
    run_block("cbc_e2", CBC_P2, CBC_C2);
    step(4'd1, 16'h0006);
    load(4'd8, {IV, 128'h0}, 8);
    run_block("cbc_d1", CBC_C1, CBC_P1);
    run_block("cbc_d2", CBC_C2, CBC_P2);
`else
    rd("iv_reserved", 4'd8, 16'h1234, 8'h00);
    rd("iv_reserved_idle", 4'd0, 16'h5678, 8'h00);
`endif

    load(4'd3, {PT0, 128'h0}, 8);
    step(4'd6, 16'h0002);
    step(4'd0, 16'h0);
    step(4'd0, 16'h0);
    rst = 1'b1;
    step(4'd0, 16'h0);
    rst = 1'b0;
    rd("rst_mid_status", 4'd5, 16'h0000, 8'h00);
    rd("rst_mid_result", 4'd7, 16'h0000, 8'h00);
    rd("rst_mid_config", 4'd6, 16'h0000, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/aes_byte_if.md
Name: aes_byte_if

Overview:
- Host-side register and serial-transfer front end for the AES datapath; instantiates the codebase's existing aes_core (round logic and key expansion).
- Accepts configuration, key, IV and data blocks as 16-bit words over a 4-bit command-address bus, and returns status and the 128-bit result as 8-bit bytes.
- Supports AES-128/256 encryption and decryption, in ECB or CBC chaining.

Parameters:
- none

Ports:
- clk       input   1   single clock; all logic on rising edge
- rst       input   1   reset, synchronous active-high
- address   input   4   command/address: 0 IDLE, 1 CONFIG, 2 KEY, 3 BLOCK, 5 STATUS, 6 START, 7 RESULT, 8 IV; other codes reserved
- data_in   input   16  write data
- data_out  output  8   registered read data

Behaviour:
- One clock; reset synchronous active-high. Reset clears config, key, block, IV/chain, status, stream counters and data_out to 0.
- data_out is registered, updated every edge from the address/state of that edge. IDLE and reserved addresses with no stream active give 0.
- CONFIG: in the same cycle, latch encdec=data_in[0] (1 = enc), keylen=data_in[1] (1 = 256), mode=data_in[2] (1 = CBC).
- START: data_in[0] init gives a 1-cycle key-expansion pulse to the core; data_in[1] next gives a 1-cycle block-process pulse.
  - Readback: data_out <= {3'b0, mode, keylen, encdec, data_in[1], data_in[0]}.
  - Example: enc/256/CBC with data 0 reads 8'b00011100.
- KEY: the cycle after the command opens a word-receive stream.
  - Captures 16 words for keylen=1 or 8 words for keylen=0, one per cycle, most significant word first, into key[255:0].
  - AES-128 keys fill key[255:128].
- BLOCK: receives 8 words into block[127:0], MSB word first.
- IV: receives 8 words into the chain register, MSB word first.
- RESULT: data_out carries result bytes over 16 consecutive edges.
  - First edge is the command cycle itself: result[127:120]. Then bytes 1..15 on the following 15 edges.
  - After the stream ends, data_out returns to 0.
- STATUS: data_out <= {6'b0, valid, ready}.
  - ready: set when the core finishes key expansion; cleared by next.
  - valid: set when the block result is stored; cleared by init or next.
- Processing on next:
  - ECB: core input = block.
  - CBC encrypt: core input = block XOR chain; when done, chain <= result.
  - CBC decrypt: core input = block; result = core output XOR chain; chain <= block (ciphertext) when done.
- Latency: key expansion ready within 20 cycles of init; result valid within 20 cycles of next (AES-256 worst case).
- Any non-IDLE address during an active stream aborts that stream and executes the new command. Words already captured stay written.
- next while a block is in flight: ignored. init while busy: ignored. next before ready: ignored.
- Config change takes effect at the next init/next. A new KEY load requires a new init.
- A second IV load mid-sequence restarts chaining.
- Reset mid-operation aborts everything and returns to the reset state.

Optional Feature:
- AES_CBC_EN defined: CBC chaining, the IV address, and the mode bit behave as above.
- AES_CBC_EN undefined:
  - mode is forced to 0 and reads back 0.
  - Address 8 is treated as reserved.
  - No chain register or XOR logic is built; all traffic is ECB.

Test Plan:
- Reset, then IDLE with data_in 16'habcd, then START with data_in 0 -> data_out 8'h00 throughout.
- CONFIG with data_in 16'h0007, then START with data_in 0 -> data_out 8'b00011100. CONFIG with 16'h0006 -> 8'b00011000.
- ECB AES-256 enc (CONFIG 16'h0003):
  - Key 000102…1f, init, poll STATUS until 8'h01.
  - BLOCK 00112233445566778899aabbccddeeff, next, poll until 8'h02.
  - RESULT -> 8ea2b7ca516745bfeafc49904b496089.
- ECB AES-128 dec (CONFIG 16'h0000): key 000102…0f, block 69c4e0d86a7b0430d8cdb78070b4c55a -> 00112233445566778899aabbccddeeff.
- CBC AES-256 enc:
  - Key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, IV 000102…0f.
  - Block 6bc1bee22e409f96e93d7e117393172a -> f58c4c04d6e5f1ba779eabfb5f7bfbd6.
  - Block ae2d8a571e03ac9c9eb76fac45af8e51 -> 9cfc4e967edb808d679f777bc6702c7d.
- CBC AES-256 dec: same key/IV, feed both ciphertexts -> both plaintexts recovered. Assert rst mid-block -> STATUS reads 8'h00.
